mac_array_acc: RTL and testbench

Parametrised successor to the weight-stationary MAC array. It has COL columns, each holding PR weights of BW bits. Activation vectors enter column 0 and ripple one column per cycle. The block adds an in-array psum accumulator per column, signed/unsigned mode, saturation, and per-column output valids. It sits between the activation SRAM/L0 feeder and the ofifo, and replaces the fixed 8x8 array.

---
 rtl/mac_array_acc_pkg.sv | 47 ++++
 rtl/mac_array_acc_if.sv | 31 +++
 rtl/mac_array_acc_col.sv | 81 ++++++++
 rtl/mac_array_acc.sv | 98 +++++++++
 tb/tb_mac_array_acc.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/mac_array_acc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : mac_pkg                                                          |
// | Brief   : Shared instruction fields, token control and saturation helper.  |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
package mac_pkg;

   localparam int INST_LOAD = 0;
   localparam int INST_EXEC = 1;
   localparam int INST_ACC  = 2;
   localparam int INST_W    = 3;

   localparam int SAT_W = 64;

   // Control half of a pipeline token; the activation payload travels
   // alongside it because its width depends on the array parameters.
   typedef struct packed {
      logic acc;
      logic sgn;
      logic vld;
   } tok_ctl_t;

   function automatic logic signed [SAT_W-1:0] sat(
      input logic signed [SAT_W-1:0] v,
      input int                      width,
      input logic                    sgn
   );
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      if (sgn) begin
         hi = (64'sd1 <<< (width - 1)) - 64'sd1;
         lo = -(64'sd1 <<< (width - 1));
      end else begin
         hi = (64'sd1 <<< width) - 64'sd1;
         lo = 64'sd0;
      end
      if (v > hi)
         sat = hi;
      else if (v < lo)
         sat = lo;
      else
         sat = v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mac_array_acc_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : mac_array_acc_if                                               |
// | Brief     : Instruction/operand bus and result bus of the MAC array.       |
// | Rev       : 1.0                                                            |
// +----------------------------------------------------------------------------+
interface mac_array_acc_if #(
   parameter int COL     = 8,
   parameter int PR      = 8,
   parameter int BW      = 4,
   parameter int BW_PSUM = 2*BW+4
);
   logic [2:0]             inst;
   logic                   is_signed;
   logic [PR*BW-1:0]       in;
   logic [COL*BW_PSUM-1:0] out;
   logic [COL-1:0]         out_valid;
   logic                   weights_ready;
   logic                   busy;

   modport master (
      output inst, is_signed, in,
      input  out, out_valid, weights_ready, busy
   );

   modport slave (
      input  inst, is_signed, in,
      output out, out_valid, weights_ready, busy
   );
endinterface
`default_nettype wire

// File: rtl/mac_array_acc_col.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mac_col_acc                                                       |
// | Brief  : One column: weights, token stage, dot product, saturating psum.   |
// | Rev    : 1.0                                                              |
// +----------------------------------------------------------------------------+
module mac_col_acc
   import mac_pkg::*;
#(
   parameter int PR      = 8,
   parameter int BW      = 4,
   parameter int BW_PSUM = 2*BW+4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wr_en,
   input  logic [PR*BW-1:0]   wr_data,
   input  logic [PR*BW-1:0]   act_in,
   input  tok_ctl_t           ctl_in,
   output logic [PR*BW-1:0]   act_q,
   output tok_ctl_t           ctl_q,
   output logic [BW_PSUM-1:0] psum,
   output logic               psum_vld
);

   localparam int DOT_W  = 2*BW + $clog2(PR) + 1;
   localparam int PROD_W = 2*BW + 2;

   logic [PR*BW-1:0]        weight;
   logic signed [BW:0]      a_l;
   logic signed [BW:0]      w_l;
   logic signed [PROD_W-1:0] prod;
   logic signed [DOT_W-1:0] dot;
   logic signed [SAT_W-1:0] psum_ext;
   logic signed [SAT_W-1:0] sum;
   logic [BW_PSUM-1:0]      psum_nxt;

   // Lanes are widened by one bit so signed and unsigned share one multiplier.
   always_comb begin
      dot  = '0;
      a_l  = '0;
      w_l  = '0;
      prod = '0;
      for (int j = 0; j < PR; j++) begin
         a_l  = {ctl_q.sgn & act_q[BW*(j+1)-1],  act_q[BW*j +: BW]};
         w_l  = {ctl_q.sgn & weight[BW*(j+1)-1], weight[BW*j +: BW]};
         prod = PROD_W'(a_l) * PROD_W'(w_l);
         dot  = dot + DOT_W'(prod);
      end
   end

   always_comb begin
      psum_ext = '0;
      sum      = SAT_W'(dot);
      if (ctl_q.acc) begin
         psum_ext = ctl_q.sgn ? SAT_W'($signed(psum)) : SAT_W'($signed({1'b0, psum}));
         sum      = psum_ext + SAT_W'(dot);
      end
      psum_nxt = BW_PSUM'(sat(sum, BW_PSUM, ctl_q.sgn));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         weight   <= '0;
         act_q    <= '0;
         ctl_q    <= '0;
         psum     <= '0;
         psum_vld <= 1'b0;
      end else begin
         if (wr_en)
            weight <= wr_data;
         act_q    <= act_in;
         ctl_q    <= ctl_in;
         psum_vld <= ctl_q.vld;
         if (ctl_q.vld)
            psum <= psum_nxt;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mac_array_acc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mac_array_acc                                                     |
// | Brief  : Weight-stationary MAC array with per-column psum accumulators.    |
// | Rev    : 1.0                                                              |
// +----------------------------------------------------------------------------+
module mac_array_acc
   import mac_pkg::*;
#(
   parameter int COL     = 8,
   parameter int PR      = 8,
   parameter int BW      = 4,
   parameter int BW_PSUM = 2*BW+4
) (
   input  logic          clk,
   input  logic          reset,
   mac_array_acc_if.slave bus
);

   localparam int PTR_W = (COL > 1) ? $clog2(COL) : 1;

   logic                 exec_en;
   logic                 load_en;
   logic [PTR_W-1:0]     ld_ptr;
   logic                 ready_q;
   logic                 busy_w;
   tok_ctl_t             head_ctl;

   logic [PR*BW-1:0]     act_q    [COL];
   tok_ctl_t             ctl_q    [COL];
   logic [BW_PSUM-1:0]   psum     [COL];
   logic                 psum_vld [COL];

   // Execute has priority: a combined load+execute only executes.
   assign exec_en  = bus.inst[INST_EXEC];
   assign load_en  = bus.inst[INST_LOAD] & ~exec_en;
   assign head_ctl = '{acc: bus.inst[INST_ACC], sgn: bus.is_signed, vld: exec_en};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ld_ptr  <= '0;
         ready_q <= 1'b0;
      end else if (load_en) begin
         if (ld_ptr == PTR_W'(COL-1)) begin
            ld_ptr  <= '0;
            ready_q <= 1'b1;
         end else begin
            ld_ptr <= ld_ptr + PTR_W'(1);
            if (ld_ptr == '0)
               ready_q <= 1'b0;
         end
      end
   end

   for (genvar k = 0; k < COL; k++) begin : g_col
      logic [PR*BW-1:0] act_src;
      tok_ctl_t         ctl_src;

      if (k == 0) begin : g_head
         assign act_src = bus.in;
         assign ctl_src = head_ctl;
      end else begin : g_chain
         assign act_src = act_q[k-1];
         assign ctl_src = ctl_q[k-1];
      end

      mac_col_acc #(
         .PR      (PR),
         .BW      (BW),
         .BW_PSUM (BW_PSUM)
      ) u_col (
         .clk      (clk),
         .reset    (reset),
         .wr_en    (load_en && (ld_ptr == PTR_W'(k))),
         .wr_data  (bus.in),
         .act_in   (act_src),
         .ctl_in   (ctl_src),
         .act_q    (act_q[k]),
         .ctl_q    (ctl_q[k]),
         .psum     (psum[k]),
         .psum_vld (psum_vld[k])
      );

      assign bus.out[k*BW_PSUM +: BW_PSUM] = psum[k];
      assign bus.out_valid[k]              = psum_vld[k];
   end

   always_comb begin
      busy_w = 1'b0;
      for (int k = 0; k < COL; k++)
         busy_w = busy_w | ctl_q[k].vld;
   end

   assign bus.busy          = busy_w;
   assign bus.weights_ready = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_array_acc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_mac_array_acc                                                  |
// | Brief  : Directed, table-driven self-checking bench for mac_array_acc.     |
// | Rev    : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mac_array_acc;
   import mac_pkg::*;

   localparam int COL     = 8;
   localparam int PR      = 8;
   localparam int BW      = 4;
   localparam int BW_PSUM = 12;
   localparam int NT      = 24;

   typedef struct {
      logic [2:0]         inst;
      logic               sgn;
      logic [BW-1:0]      v;
      logic               chk;
      logic [BW_PSUM-1:0] exp;
      logic               exp_wr;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   n_vec = 0;
   int   n_bad = 0;
   vec_t tbl [NT];

   mac_array_acc_if #(.COL(COL), .PR(PR), .BW(BW), .BW_PSUM(BW_PSUM)) bus ();

   mac_array_acc #(.COL(COL), .PR(PR), .BW(BW), .BW_PSUM(BW_PSUM)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [PR*BW-1:0] rep(input logic [BW-1:0] v);
      logic [PR*BW-1:0] r;
      for (int j = 0; j < PR; j++)
         r[BW*j +: BW] = v;
      return r;
   endfunction

   function automatic logic [BW_PSUM-1:0] col_out(input int k);
      return bus.out[k*BW_PSUM +: BW_PSUM];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] i, input logic s, input logic [BW-1:0] v);
      bus.inst      = i;
      bus.is_signed = s;
      bus.in        = rep(v);
   endtask

   task automatic idle();
      bus.inst = 3'b000;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic set_row(input int i, input logic [2:0] inst, input logic sgn,
                          input logic [BW-1:0] v, input logic chk,
                          input logic [BW_PSUM-1:0] exp, input logic exp_wr);
      tbl[i] = '{inst: inst, sgn: sgn, v: v, chk: chk, exp: exp, exp_wr: exp_wr};
   endtask

   initial begin
      // Reload all columns with 15, unsigned accumulate to saturation,
      // reload with 7, signed accumulate of -8 activations to clamp.
      for (int i = 0; i < 8; i++)
         set_row(i, 3'b001, 1'b0, 4'hF, 1'b0, 12'd0, i == 7);
      set_row(8,  3'b010, 1'b0, 4'hF, 1'b1, 12'd1800, 1'b1);
      set_row(9,  3'b110, 1'b0, 4'hF, 1'b1, 12'd3600, 1'b1);
      set_row(10, 3'b110, 1'b0, 4'hF, 1'b1, 12'd4095, 1'b1);
      for (int i = 0; i < 8; i++)
         set_row(11 + i, 3'b001, 1'b0, 4'h7, 1'b0, 12'd0, i == 7);
      set_row(19, 3'b010, 1'b1, 4'h8, 1'b1, 12'hE40, 1'b1);
      set_row(20, 3'b110, 1'b1, 4'h8, 1'b1, 12'hC80, 1'b1);
      set_row(21, 3'b110, 1'b1, 4'h8, 1'b1, 12'hAC0, 1'b1);
      set_row(22, 3'b110, 1'b1, 4'h8, 1'b1, 12'h900, 1'b1);
      set_row(23, 3'b110, 1'b1, 4'h8, 1'b1, 12'h800, 1'b1);

      reset         = 1'b0;
      bus.inst      = 3'b000;
      bus.is_signed = 1'b0;
      bus.in        = '0;
      repeat (2) tick();
      check("reset_out",   32'(bus.out == '0), 32'd1);
      check("reset_valid", 32'(bus.out_valid), 32'd0);
      check("reset_busy",  32'(bus.busy), 32'd0);
      check("reset_wr",    32'(bus.weights_ready), 32'd0);
      reset = 1'b1;
      tick();

      // Column k weights = k+1, then one unsigned execute of all-ones.
      for (int k = 0; k < COL; k++) begin
         drive(3'b001, 1'b0, 4'(k + 1));
         tick();
         if (k == COL - 2)
            check("wr_before_last", 32'(bus.weights_ready), 32'd0);
      end
      idle();
      check("wr_after_last", 32'(bus.weights_ready), 32'd1);
      drive(3'b010, 1'b0, 4'h1);
      tick();
      idle();
      for (int k = 0; k < COL; k++) begin
         tick();
         check("t1_valid", 32'(bus.out_valid), 32'(1 << k));
         check("t1_out",   32'(col_out(k)), 32'(8 * (k + 1)));
         check("t1_busy",  32'(bus.busy), 32'(k < COL - 1));
      end

      for (int i = 0; i < NT; i++) begin
         drive(tbl[i].inst, tbl[i].sgn, tbl[i].v);
         tick();
         idle();
         tick();
         if (tbl[i].chk) begin
            check("tbl_out0",   32'(col_out(0)), 32'(tbl[i].exp));
            check("tbl_valid0", 32'(bus.out_valid[0]), 32'd1);
         end
         check("tbl_wr", 32'(bus.weights_ready), 32'(tbl[i].exp_wr));
      end
      repeat (COL) tick();
      for (int k = 0; k < COL; k++)
         check("clamp_col", 32'(col_out(k)), 32'h800);

      // Load+execute mid-load must execute only and leave ld_ptr alone.
      for (int k = 0; k < 3; k++) begin
         drive(3'b001, 1'b0, 4'h1);
         tick();
      end
      drive(3'b011, 1'b0, 4'h2);
      tick();
      idle();
      repeat (COL) tick();
      check("ldex_col0", 32'(col_out(0)), 32'd16);
      check("ldex_col3", 32'(col_out(3)), 32'd112);
      check("ldex_col7", 32'(col_out(7)), 32'd112);
      check("ldex_wr",   32'(bus.weights_ready), 32'd0);
      drive(3'b001, 1'b0, 4'h3);
      tick();
      drive(3'b010, 1'b0, 4'h1);
      tick();
      idle();
      repeat (COL) tick();
      check("ldex_next_col3", 32'(col_out(3)), 32'd24);
      check("ldex_next_col2", 32'(col_out(2)), 32'd8);
      check("ldex_next_col4", 32'(col_out(4)), 32'd56);

      // Rewrite column 3 while the token sits two columns upstream.
      for (int k = 0; k < 7; k++) begin
         drive(3'b001, 1'b0, 4'h1);
         tick();
      end
      drive(3'b010, 1'b0, 4'h1);
      tick();
      drive(3'b001, 1'b0, 4'h2);
      tick();
      idle();
      repeat (COL) tick();
      check("reload_col3", 32'(col_out(3)), 32'd16);
      check("reload_col0", 32'(col_out(0)), 32'd8);
      check("reload_col2", 32'(col_out(2)), 32'd8);
      check("reload_col4", 32'(col_out(4)), 32'd8);

      // Reset in the middle of three back-to-back executes.
      for (int k = 0; k < 4; k++) begin
         drive(3'b001, 1'b0, 4'h1);
         tick();
      end
      check("pre_rst_wr", 32'(bus.weights_ready), 32'd1);
      for (int k = 0; k < 3; k++) begin
         drive(3'b010, 1'b0, 4'h1);
         tick();
      end
      idle();
      check("pre_rst_busy", 32'(bus.busy), 32'd1);
      reset = 1'b0;
      #1;
      check("rst_out",   32'(bus.out == '0), 32'd1);
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_busy",  32'(bus.busy), 32'd0);
      check("rst_wr",    32'(bus.weights_ready), 32'd0);
      repeat (2) tick();
      reset = 1'b1;
      for (int k = 0; k < COL + 2; k++) begin
         tick();
         check("post_rst_valid", 32'(bus.out_valid), 32'd0);
      end
      check("post_rst_out", 32'(bus.out == '0), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
